// File: rtl/serial_div_pkg.sv
// Shared types and mod-5 helpers for the serial divisibility-by-5 encoder.
package serial_div_pkg;

    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    typedef enum logic [2:0] {mod_0, mod_1, mod_2, mod_3, mod_4} residue_t;

    // (2m + b) mod 5
    function automatic residue_t next_mod(input residue_t m, input logic b);
        residue_t r;
        case (m)
            mod_0:   r = b ? mod_1 : mod_0;
            mod_1:   r = b ? mod_3 : mod_2;
            mod_2:   r = b ? mod_0 : mod_4;
            mod_3:   r = b ? mod_2 : mod_1;
            mod_4:   r = b ? mod_4 : mod_3;
            default: r = mod_0;
        endcase
        return r;
    endfunction

    // r = 2m mod 5, so that 8m + r is a multiple of 5
    function automatic logic [2:0] check_bits(input residue_t m);
        logic [2:0] r;
        case (m)
            mod_0:   r = 3'd0;
            mod_1:   r = 3'd2;
            mod_2:   r = 3'd4;
            mod_3:   r = 3'd1;
            mod_4:   r = 3'd3;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_mod5_tracker.sv
// Running residue of the MSB-first bitstream sent so far, modulo 5.
module serial_mod5_tracker
    import serial_div_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     step,
    input  logic     data_bit,
    output residue_t residue
);

    always_ff @(posedge clk) begin
        if (rst || clear)
            residue <= mod_0;
        else if (step)
            residue <= next_mod(residue, data_bit);
    end

endmodule

// File: rtl/serial_div_by_5_encoder.sv
// Shifts out a W-bit word MSB-first followed by 3 check bits that make the
// whole frame a multiple of 5.
module serial_div_by_5_encoder
    import serial_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_bit,
    output logic         out_first,
    output logic         out_last
);

    localparam int CW = $clog2(W + 3);
    localparam logic [CW-1:0] CNT_DMAX = CW'(W - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W + 2);

    state_t        state, state_next;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [2:0]    r_sh;
    residue_t      residue;
    logic          beat, accept;

    assign out_valid = (state != IDLE);
    assign beat      = out_valid && out_ready;
    assign out_first = (state == DATA) && (cnt == '0);
    assign out_last  = (state == CHECK) && (cnt == CNT_LAST);
    assign out_bit   = (state == DATA)  ? shreg[W-1] :
                       (state == CHECK) ? r_sh[2]    : 1'b0;
    // Ready again during the final beat so frames can run back to back.
    assign in_ready  = !rst && ((state == IDLE) || (beat && out_last));
    assign accept    = in_valid && in_ready;

    serial_mod5_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .step     (beat && (state == DATA)),
        .data_bit (shreg[W-1]),
        .residue  (residue)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DATA;
            DATA:    if (beat && cnt == CNT_DMAX) state_next = CHECK;
            CHECK:   if (beat && out_last) state_next = accept ? DATA : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            r_sh  <= '0;
        end else if (accept) begin
            shreg <= in_data;
            cnt   <= '0;
        end else if (beat) begin
            cnt <= cnt + CW'(1);
            if (state == DATA) begin
                shreg <= shreg << 1;
                // Fold in the outgoing last data bit before mapping to r.
                if (cnt == CNT_DMAX)
                    r_sh <= check_bits(next_mod(residue, shreg[W-1]));
            end else begin
                r_sh <= r_sh << 1;
            end
        end
    end

endmodule

// File: tb/tb_serial_div_by_5_encoder.sv
// Directed bench for the div-by-5 encoder: W=8 and W=1 builds side by side.
module tb_serial_div_by_5_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data;
    logic       out_bit, out_first, out_last;
    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] in_data1;
    logic       out_bit1, out_first1, out_last1;

    int tests = 0;
    int fails = 0;
    int ck    = 0;

    always #5 clk = ~clk;

    serial_div_by_5_encoder #(.W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_first(out_first), .out_last(out_last)
    );

    serial_div_by_5_encoder #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_bit(out_bit1), .out_first(out_first1), .out_last(out_last1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks an 11-bit frame beat by beat; optional 5-cycle stall before beat stall_at.
    task automatic expect_frame(input string tag, input logic [10:0] exp, input int stall_at);
        for (int i = 0; i < 11; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #0;
                    chk({tag, " stall valid"}, out_valid, 1'b1);
                    chk({tag, " stall bit"},   out_bit,   exp[10-i]);
                    chk({tag, " stall first"}, out_first, i == 0);
                    chk({tag, " stall last"},  out_last,  i == 10);
                    chk({tag, " stall ready"}, in_ready,  1'b0);
                    tick();
                end
                out_ready = 1'b1;
                #0;
            end
            chk({tag, " valid"}, out_valid, 1'b1);
            chk({tag, " bit"},   out_bit,   exp[10-i]);
            chk({tag, " first"}, out_first, i == 0);
            chk({tag, " last"},  out_last,  i == 10);
            chk({tag, " in_ready"}, in_ready, i == 10);
            ck = (2 * ck + int'(out_bit)) % 5;
            if (i == 10) chk({tag, " checker"}, ck, 0);
            tick();
        end
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #0;
        chk("handshake ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send1(input string tag, input logic d, input logic [3:0] exp);
        in_valid1 = 1'b1;
        in_data1  = d;
        tick();
        in_valid1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, " valid"}, out_valid1, 1'b1);
            chk({tag, " bit"},   out_bit1,   exp[3-i]);
            chk({tag, " first"}, out_first1, i == 0);
            chk({tag, " last"},  out_last1,  i == 3);
            tick();
        end
        chk({tag, " idle"}, out_valid1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
        tick(); tick();
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready",  in_ready,  1'b0);
        chk("reset out_bit",   out_bit,   1'b0);
        chk("reset out_first", out_first, 1'b0);
        chk("reset out_last",  out_last,  1'b0);
        rst = 1'b0;
        #0;
        chk("post-reset in_ready", in_ready, 1'b1);

        send(8'h01); expect_frame("h01", 11'b00000001_010, -1);
        chk("h01 idle", out_valid, 1'b0);
        send(8'hFF); expect_frame("hFF", 11'b11111111_000, -1);
        send(8'h07); expect_frame("h07", 11'b00000111_100, -1);

        // Back to back: second word taken on the first frame's last beat.
        send(8'h03);
        in_valid = 1'b1;
        in_data  = 8'h0C;
        expect_frame("h03", 11'b00000011_001, -1);
        in_valid = 1'b0;
        expect_frame("h0C", 11'b00001100_100, -1);
        chk("b2b idle", out_valid, 1'b0);

        send(8'hA5); expect_frame("hA5", 11'b10100101_000, 4);

        // Abort mid-frame while bit 4 is presented.
        send(8'h5A);
        for (int i = 0; i < 4; i++) tick();
        chk("abort bit4", out_bit, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #0;
        chk("abort out_valid", out_valid, 1'b0);
        chk("abort in_ready",  in_ready,  1'b1);
        chk("abort out_last",  out_last,  1'b0);
        send(8'h02); expect_frame("h02", 11'b00000010_100, -1);

        send1("w1 d1", 1'b1, 4'b1_010);
        send1("w1 d0", 1'b0, 4'b0_000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_div_by_5_encoder.md
# serial_div_by_5_encoder

Serial transmitter that produces bitstreams for the serial divisibility-by-5 checker. It accepts a W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per accepted output beat. It then appends 3 check bits so that the whole transmitted number is divisible by 5. A checker on the far end therefore reports div_by_5 = 1 exactly after the last bit of every well-formed frame, including back-to-back frames sent with no checker reset.

## Interface
- W, default 8: data word width; legal range W ≥ 1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  encoder accepts a word this cycle.
- in_data  in  W  word to transmit, MSB sent first.
- out_valid  out  1  out_bit is valid.
- out_ready  in  1  sink accepts out_bit this cycle.
- out_bit  out  1  current serial bit.
- out_first  out  1  out_bit is the first bit of a frame (data MSB).
- out_last  out  1  out_bit is the last bit of a frame (check bit 0).

## Operation
- Frame: W data bits, MSB first, then 3 check bits r[2:0], MSB first. Frame length is W+3.
- Running residue m tracks the data bits sent so far. It resets to 0 at frame start. On each data-bit beat, m ← (2m + bit) mod 5.
- Check value r = (2·m_final) mod 5, so D·8 + r ≡ 0 (mod 5). Mapping from m to r: 0→0, 1→2, 2→4, 3→1, 4→3. r always fits in 3 bits.
- State machine:
  - IDLE: in_ready = 1, out_valid = 0. An input handshake loads the shift register with in_data and moves to DATA.
  - DATA: out_bit = shift register MSB. Each beat (out_valid & out_ready) shifts left and updates m. The beat carrying data bit 0 latches r and moves to CHECK.
  - CHECK: out_bit = r[2−idx]. The beat on idx = 2 ends the frame. The next state is DATA if a new word is accepted in the same cycle, otherwise IDLE.
- Back-to-back frames: in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is a combinational path from out_ready to in_ready by design.
- Bit counter width is $clog2(W+3). It counts beats within the frame, not cycles.
- out_first = DATA & counter==0. out_last = CHECK & idx==2.
- Stall: while out_valid & !out_ready, out_bit, out_first, out_last, m and the counter hold unchanged.
- Reset:
  - Reset values: state IDLE, out_valid 0, out_bit 0, out_first 0, out_last 0, m 0.
  - in_ready is driven 0 while rst is high.
  - rst asserted mid-frame aborts the frame. The remaining bits are never sent, and no out_last is produced for it.

## Timing
- Input handshake in cycle N: the first bit (out_first = 1) appears with out_valid = 1 in cycle N+1.
- With out_ready held high, the frame occupies cycles N+1 … N+W+3. out_last appears in cycle N+W+3.
- Back-to-back throughput: one bit per cycle with no bubble between frames when in_valid and out_ready stay high.
- in_data is sampled only on the handshake cycle. It may change afterwards.
- The first in_ready = 1 occurs in the first cycle after rst deasserts.

## Structure
- Package serial_div_pkg holds:
  - state enum (IDLE, DATA, CHECK);
  - residue enum mod_0..mod_4 (3-bit);
  - function next_mod(residue, bit);
  - function check_bits(residue) implementing the m→r map.
- Sub-module serial_mod5_tracker: the residue FSM with inputs clk, rst, clear, step, bit and output residue. It updates only on step. clear forces mod_0, and clear has priority over step.
- The top level contains the frame FSM, shift register, beat counter and handshake logic.

## Test plan
- W=8, in_data=8'h01, out_ready=1 → stream 00000001_010 (value 10). out_first on the 1st beat, out_last on the 11th. A reference div-by-5 checker reads 1 after the last bit.
- in_data=8'hFF → 11111111_000 (2040). in_data=8'h07 → 00000111_100 (60).
- 8'h03 then 8'h0C with in_valid held high:
  - the second word is accepted in the cycle of the first frame's out_last;
  - the streams are 00000011_001 (25) and then 00001100_100 (100) with zero bubble cycles;
  - a checker with no reset between frames reads 1 after each out_last.
- out_ready low for 5 cycles after data bit 3 of 8'hA5 → out_bit, out_first and out_last stay stable. The full stream 10100101_000 (1320) is delivered with no skipped or duplicated bit.
- rst pulsed for 1 cycle while bit 4 of a frame is presented:
  - out_valid is 0 in the next cycle and in_ready is 1 one cycle after rst deasserts;
  - a new word 8'h02 then produces 00000010_100 (20) with correct out_first.
- W=1 build, in_data=1 → 1_010 (10). in_data=0 → 0_000.
